// File: rtl/mmio_timer.sv
// Memory-mapped timer on the CPU data bus: prescaler, up-counter with compare,
// one-shot/periodic modes, sticky W1C status and a level interrupt.
module mmio_timer #(
   parameter logic [15:0] BASE_ADDR    = 16'hFF00,
   parameter logic [15:0] PRESCALE_RST = 16'h0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] mem_access_addr,
   input  logic [15:0] mem_write_data,
   input  logic        mem_write_en,
   input  logic        mem_read,
   output logic [15:0] mem_read_data,
   output logic        hit,
   output logic        irq,
   output logic        tick
);

   logic        r_en;
   logic        r_mode;
   logic        r_irq_en;
   logic [15:0] r_prescale;
   logic [15:0] r_period;
   logic [15:0] r_count;
   logic [15:0] r_pcnt;
   logic        r_exp;
   logic        r_ovr;

   logic        w_hit;
   logic [2:0]  w_sel;
   logic        w_wr;
   logic        w_wr_ctrl;
   logic        w_wr_pre;
   logic        w_wr_per;
   logic        w_wr_cnt;
   logic        w_wr_stat;
   logic        w_clr;
   logic        w_tick;
   logic        w_cnt_upd;
   logic        w_expire;
   logic [15:0] w_rdata;

   assign w_hit     = (mem_access_addr[15:4] == BASE_ADDR[15:4]);
   assign w_sel     = mem_access_addr[3:1];
   assign w_wr      = mem_write_en & w_hit;
   assign w_wr_ctrl = w_wr & (w_sel == 3'd0);
   assign w_wr_pre  = w_wr & (w_sel == 3'd1);
   assign w_wr_per  = w_wr & (w_sel == 3'd2);
   assign w_wr_cnt  = w_wr & (w_sel == 3'd3);
   assign w_wr_stat = w_wr & (w_sel == 3'd4);
   assign w_clr     = w_wr_ctrl & mem_write_data[3];

   assign w_tick    = r_en & (r_pcnt == r_prescale);
   // A software COUNT load or CLR takes precedence over the tick's count step.
   assign w_cnt_upd = w_tick & ~w_wr_cnt & ~w_clr;
   assign w_expire  = w_cnt_upd & (r_count == r_period);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_en       <= 1'b0;
         r_mode     <= 1'b0;
         r_irq_en   <= 1'b0;
         r_prescale <= PRESCALE_RST;
         r_period   <= 16'h0000;
         r_count    <= 16'h0000;
         r_pcnt     <= 16'h0000;
         r_exp      <= 1'b0;
         r_ovr      <= 1'b0;
      end else begin
         if (w_wr_ctrl) begin
            r_en     <= mem_write_data[0];
            r_mode   <= mem_write_data[1];
            r_irq_en <= mem_write_data[2];
         end else if (w_expire && !r_mode) begin
            r_en <= 1'b0;
         end

         if (w_wr_pre) r_prescale <= mem_write_data;
         if (w_wr_per) r_period   <= mem_write_data;

         if (w_wr_cnt || w_clr)
            r_pcnt <= 16'h0000;
         else if (w_tick)
            r_pcnt <= 16'h0000;
         else if (r_en)
            r_pcnt <= r_pcnt + 16'h0001;

         if (w_wr_cnt)
            r_count <= mem_write_data;
         else if (w_clr)
            r_count <= 16'h0000;
         else if (w_cnt_upd)
            r_count <= w_expire ? 16'h0000 : r_count + 16'h0001;

         // Hardware set beats a simultaneous W1C clear.
         r_exp <= (r_exp & ~(w_wr_stat & mem_write_data[0])) | w_expire;
         r_ovr <= (r_ovr & ~(w_wr_stat & mem_write_data[1])) | (w_expire & r_exp);
      end
   end

   always_comb begin
      w_rdata = 16'h0000;
      if (mem_read && w_hit) begin
         case (w_sel)
            3'd0:    w_rdata = {13'd0, r_irq_en, r_mode, r_en};
            3'd1:    w_rdata = r_prescale;
            3'd2:    w_rdata = r_period;
            3'd3:    w_rdata = r_count;
            3'd4:    w_rdata = {14'd0, r_ovr, r_exp};
            default: w_rdata = 16'h0000;
         endcase
      end
   end

   assign mem_read_data = w_rdata;
   assign hit           = w_hit;
   assign irq           = r_exp & r_irq_en;
   assign tick          = w_tick;

endmodule

// File: tb/tb_mmio_timer.sv
// Self-checking bench for mmio_timer: bus reads go through a scoreboard queue,
// timing of tick/COUNT/STATUS is predicted from cycle phase after each enable.
module tb_mmio_timer;

   localparam logic [15:0] A_CTRL = 16'hFF00;
   localparam logic [15:0] A_PRE  = 16'hFF02;
   localparam logic [15:0] A_PER  = 16'hFF04;
   localparam logic [15:0] A_CNT  = 16'hFF06;
   localparam logic [15:0] A_STAT = 16'hFF08;

   logic        clk;
   logic        reset;
   logic [15:0] mem_access_addr;
   logic [15:0] mem_write_data;
   logic        mem_write_en;
   logic        mem_read;
   logic [15:0] mem_read_data;
   logic        hit;
   logic        irq;
   logic        tick;

   int n_checks;
   int n_errors;
   logic [16:0] sb_q[$];

   mmio_timer #(.BASE_ADDR(16'hFF00), .PRESCALE_RST(16'h0000)) dut (
      .clk             (clk),
      .reset           (reset),
      .mem_access_addr (mem_access_addr),
      .mem_write_data  (mem_write_data),
      .mem_write_en    (mem_write_en),
      .mem_read        (mem_read),
      .mem_read_data   (mem_read_data),
      .hit             (hit),
      .irq             (irq),
      .tick            (tick)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Called at a negedge; the write lands on the following posedge.
   task automatic wr(input logic [15:0] a, input logic [15:0] d);
      mem_access_addr = a;
      mem_write_data  = d;
      mem_write_en    = 1'b1;
      @(negedge clk);
      mem_write_en    = 1'b0;
   endtask

   task automatic rd(input logic [15:0] a, input logic [15:0] ed, input logic eh,
                     input string tag);
      logic [16:0] e;
      sb_q.push_back({eh, ed});
      mem_access_addr = a;
      mem_read        = 1'b1;
      #1;
      e = sb_q.pop_front();
      chk(tag, {15'd0, hit, mem_read_data}, {15'd0, e});
      mem_read = 1'b0;
   endtask

   initial begin
      logic [15:0] seq5[5];
      logic [15:0] a;
      n_checks = 0;
      n_errors = 0;
      reset = 1'b1;
      mem_access_addr = 16'h0000;
      mem_write_data  = 16'h0000;
      mem_write_en    = 1'b0;
      mem_read        = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      // 1: reset values across the window and an out-of-window read
      chk("rst_irq", irq, 0);
      chk("rst_tick", tick, 0);
      for (int i = 0; i < 8; i++) begin
         a = 16'hFF00 + 16'(2 * i);
         rd(a, 16'h0000, 1'b1, "rst_reg");
         @(negedge clk);
      end
      rd(16'hFE00, 16'h0000, 1'b0, "miss");
      @(negedge clk);

      // 2: periodic, PRESCALE=3, PERIOD=4
      wr(A_PRE, 16'd3);
      wr(A_PER, 16'd4);
      wr(16'hFE02, 16'h0055);
      rd(A_PRE, 16'd3, 1'b1, "nohit_wr");
      mem_access_addr = A_PRE;
      #1 chk("noread", mem_read_data, 0);
      @(negedge clk);
      wr(A_CTRL, 16'h0007);
      for (int k = 0; k <= 20; k++) begin
         chk("p_tick", tick, (k % 4 == 3) ? 1 : 0);
         rd(A_CNT, 16'((k / 4) % 5), 1'b1, "p_count");
         if (k == 19) chk("p_irq_lo", irq, 0);
         if (k == 20) begin
            chk("p_irq_hi", irq, 1);
            rd(A_STAT, 16'h0001, 1'b1, "p_stat");
         end
         @(negedge clk);
      end
      repeat (3) @(negedge clk);
      rd(A_CNT, 16'd1, 1'b1, "p_continue");
      @(negedge clk);

      // 3: one-shot, PRESCALE=0, PERIOD=2
      wr(A_CTRL, 16'h0008);
      wr(A_STAT, 16'h0003);
      wr(A_PRE, 16'd0);
      wr(A_PER, 16'd2);
      rd(A_STAT, 16'h0000, 1'b1, "os_stat_clr");
      @(negedge clk);
      wr(A_CTRL, 16'h0005);
      repeat (3) @(negedge clk);
      rd(A_STAT, 16'h0001, 1'b1, "os_exp");
      rd(A_CTRL, 16'h0004, 1'b1, "os_ctrl");
      rd(A_CNT, 16'h0000, 1'b1, "os_count");
      repeat (5) @(negedge clk);
      rd(A_CNT, 16'h0000, 1'b1, "os_hold");
      chk("os_tick", tick, 0);
      chk("os_irq", irq, 1);
      @(negedge clk);

      // 4: overrun, W1C, and W1C colliding with an expiry
      wr(A_CTRL, 16'h0005);
      repeat (3) @(negedge clk);
      rd(A_STAT, 16'h0003, 1'b1, "ovr_set");
      @(negedge clk);
      wr(A_STAT, 16'h0001);
      rd(A_STAT, 16'h0002, 1'b1, "w1c_exp");
      chk("w1c_irq", irq, 0);
      @(negedge clk);
      wr(A_CTRL, 16'h0005);
      repeat (2) @(negedge clk);
      wr(A_STAT, 16'h0003);
      rd(A_STAT, 16'h0001, 1'b1, "w1c_vs_set");
      chk("w1c_vs_irq", irq, 1);
      @(negedge clk);

      // 5: COUNT above PERIOD wraps through 0xFFFF
      wr(A_CTRL, 16'h0000);
      wr(A_PER, 16'd1);
      wr(A_CNT, 16'hFFFE);
      wr(A_STAT, 16'h0003);
      wr(A_CTRL, 16'h0003);
      seq5 = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001, 16'h0000};
      for (int k = 0; k < 5; k++) begin
         rd(A_CNT, seq5[k], 1'b1, "wrap_count");
         if (k == 3) rd(A_STAT, 16'h0000, 1'b1, "wrap_noexp");
         if (k == 4) rd(A_STAT, 16'h0001, 1'b1, "wrap_exp");
         @(negedge clk);
      end
      chk("wr_tick_pre", tick, 1);
      wr(A_CNT, 16'h1234);
      rd(A_CNT, 16'h1234, 1'b1, "cnt_wr_tick");
      @(negedge clk);
      rd(A_CNT, 16'h1235, 1'b1, "cnt_after_wr");
      @(negedge clk);

      // 6: asynchronous reset mid-count
      wr(A_CTRL, 16'h0000);
      wr(A_PRE, 16'd3);
      wr(A_PER, 16'd10);
      wr(A_CNT, 16'd3);
      wr(A_CTRL, 16'h0007);
      rd(A_CNT, 16'd3, 1'b1, "pre_rst_cnt");
      chk("pre_rst_irq", irq, 1);
      reset = 1'b1;
      #1;
      chk("rst_irq_now", irq, 0);
      rd(A_CNT, 16'h0000, 1'b1, "rst_cnt");
      rd(A_STAT, 16'h0000, 1'b1, "rst_stat");
      @(negedge clk);
      rd(A_CTRL, 16'h0000, 1'b1, "rst_ctrl");
      rd(A_PRE, 16'h0000, 1'b1, "rst_pre");
      @(negedge clk);
      reset = 1'b0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         chk("post_rst_tick", tick, 0);
      end
      chk("post_rst_irq", irq, 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
